// File: rtl/dp_ram_arb_pkg.sv
// Shared helpers for the dual-port RAM read-port arbiter.
// Latency: n/a (functions only).
// Backpressure: n/a.
package dp_ram_arb_pkg;

  // Requester id width, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Cycles from grant to response for an isolated read (1 + KNOB_REGOUT).
  function automatic int rd_latency(input int knob_regout);
    return 1 + ((knob_regout != 0) ? 1 : 0);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: search starts one past ptr and wraps, first request wins.
// Latency: purely combinational.
// Backpressure: none; gnt is zero when no request is asserted.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id
);

  // Walk offsets from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    for (int k = N; k >= 1; k--) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && (((int'(ptr) + k) % N) == i)) begin
          gnt    = '0;
          gnt[i] = 1'b1;
          gnt_id = ID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/dp_ram_rd_arb.sv
// Shares one RAM read port among NUM_REQ requesters, tagging each read with its id.
// Latency: 1 cycle (KNOB_REGOUT=0) or 2 cycles (KNOB_REGOUT=1) from grant to rsp_valid.
// Backpressure: requesters see a combinational one-hot req_ready; responses cannot be stalled.
module dp_ram_rd_arb
  import dp_ram_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 256,
  parameter int KNOB_REGOUT = 0,
  parameter int ID_WIDTH    = clog2_min1(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          ram_rd_en,
  output logic [ADDR_WIDTH-1:0]         ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]         ram_rd_data,
  output logic                          rsp_valid,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          busy
);

  // With the output register the RAM pipeline only moves on rd_en, so one
  // read tag is held until the next read (real or flush) pushes its data out.
  localparam logic REGOUT = (KNOB_REGOUT != 0);

  logic [NUM_REQ-1:0]    w_gnt;
  logic [ID_WIDTH-1:0]   w_gnt_id;
  logic                  w_any;
  logic                  w_flush;
  logic [ADDR_WIDTH-1:0] w_req_addr;

  logic [ID_WIDTH-1:0]   r_rr_ptr;
  logic [ADDR_WIDTH-1:0] r_last_addr;
  logic                  r_pending_vld;
  logic [ID_WIDTH-1:0]   r_pending_id;
  logic                  r_rsp_valid;
  logic [ID_WIDTH-1:0]   r_rsp_id;

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_WIDTH)
  ) u_rr_arbiter (
    .req    (req_valid),
    .ptr    (r_rr_ptr),
    .gnt    (w_gnt),
    .gnt_id (w_gnt_id)
  );

  // Any asserted request is granted this cycle, so it is a real read.
  assign w_any   = |req_valid;
  // Idle cycle with a read still inside the RAM pipeline: push it out.
  assign w_flush = REGOUT & ~w_any & r_pending_vld;

  // Select the winner's address slice.
  always_comb begin
    w_req_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) w_req_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  assign req_ready   = w_gnt;
  assign ram_rd_en   = w_any | w_flush;
  // Flush reads repeat the last address so the RAM address stays stable.
  assign ram_rd_addr = w_any ? w_req_addr : r_last_addr;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_data    = ram_rd_data;
  assign busy        = r_pending_vld | r_rsp_valid;

  // Round-robin pointer and last read address advance only on real reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr    <= ID_WIDTH'(NUM_REQ - 1);
      r_last_addr <= '0;
    end else if (w_any) begin
      r_rr_ptr    <= w_gnt_id;
      r_last_addr <= w_req_addr;
    end
  end

  // Read tag tracking and response generation; reset drops any in-flight tag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending_vld <= 1'b0;
      r_pending_id  <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= '0;
    end else if (REGOUT) begin
      // A pending tag always leaves: either a real read or a flush follows it.
      r_rsp_valid   <= r_pending_vld;
      r_rsp_id      <= r_pending_id;
      r_pending_vld <= w_any;
      if (w_any) r_pending_id <= w_gnt_id;
    end else begin
      r_rsp_valid   <= w_any;
      r_rsp_id      <= w_gnt_id;
      r_pending_vld <= 1'b0;
      r_pending_id  <= '0;
    end
  end

endmodule

// File: tb/tb_dp_ram_rd_arb.sv
// Bench for dp_ram_rd_arb: one instance per output-register setting, shared request stimulus.
// Latency: each instance drives its own behavioural RAM read pipeline.
// Backpressure: none on responses; requests are held by the bench as needed.
module tb_dp_ram_rd_arb;

  localparam int NR = 4;
  localparam int AW = 10;
  localparam int DW = 256;
  localparam int IW = 2;

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*AW-1:0] req_addr;

  logic [NR-1:0] req_ready0, req_ready1;
  logic          rd_en0, rd_en1;
  logic [AW-1:0] rd_addr0, rd_addr1;
  logic [DW-1:0] rd_data0, rd_data1;
  logic          rsp_valid0, rsp_valid1;
  logic [IW-1:0] rsp_id0, rsp_id1;
  logic [DW-1:0] rsp_data0, rsp_data1;
  logic          busy0, busy1;

  logic [DW-1:0] ram0_q;
  logic [DW-1:0] ram1_s1, ram1_s2;

  int n_pass  = 0;
  int n_total = 0;

  dp_ram_rd_arb #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .KNOB_REGOUT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready0), .ram_rd_en(rd_en0), .ram_rd_addr(rd_addr0),
    .ram_rd_data(rd_data0), .rsp_valid(rsp_valid0), .rsp_id(rsp_id0),
    .rsp_data(rsp_data0), .busy(busy0)
  );

  dp_ram_rd_arb #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .KNOB_REGOUT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready1), .ram_rd_en(rd_en1), .ram_rd_addr(rd_addr1),
    .ram_rd_data(rd_data1), .rsp_valid(rsp_valid1), .rsp_id(rsp_id1),
    .rsp_data(rsp_data1), .busy(busy1)
  );

  // RAM contents: address in the top bits, low byte = addr ^ 0xA0 (RAM[5] = 0xA5).
  function automatic logic [DW-1:0] mdat(input logic [AW-1:0] a);
    return {a, 238'(0), 8'(a[7:0] ^ 8'hA0)};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-stage RAM read.
  always @(posedge clk) if (rd_en0) ram0_q <= mdat(rd_addr0);
  // Two enable-gated stages: array read then output register.
  always @(posedge clk) if (rd_en1) begin
    ram1_s1 <= mdat(rd_addr1);
    ram1_s2 <= ram1_s1;
  end
  assign rd_data0 = ram0_q;
  assign rd_data1 = ram1_s2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '1;
    req_addr = '0;
    tick(); tick(); #1;
    n_total++; if (rsp_valid0 !== 1'b0) $display("FAIL reset_rsp_valid0 got %b want 0", rsp_valid0); else n_pass++;
    n_total++; if (rsp_valid1 !== 1'b0) $display("FAIL reset_rsp_valid1 got %b want 0", rsp_valid1); else n_pass++;
    n_total++; if (rsp_id1 !== 2'd0) $display("FAIL reset_rsp_id1 got %0d want 0", rsp_id1); else n_pass++;
    n_total++; if (busy0 !== 1'b0 || busy1 !== 1'b0) $display("FAIL reset_busy got %b%b want 00", busy0, busy1); else n_pass++;
    n_total++; if (req_ready0 !== 4'b0001) $display("FAIL reset_prio got %b want 0001", req_ready0); else n_pass++;
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_single_k0();
    req_valid = 4'b0100;
    req_addr[2*AW +: AW] = 10'h005;
    #1;
    n_total++; if (req_ready0 !== 4'b0100) $display("FAIL k0_grant got %b want 0100", req_ready0); else n_pass++;
    n_total++; if (rd_en0 !== 1'b1 || rd_addr0 !== 10'h005) $display("FAIL k0_rd got en=%b addr=%h want en=1 addr=005", rd_en0, rd_addr0); else n_pass++;
    tick();
    req_valid = '0;
    #1;
    n_total++; if ({rsp_valid0, rsp_id0} !== {1'b1, 2'd2}) $display("FAIL k0_rsp got v=%b id=%0d want v=1 id=2", rsp_valid0, rsp_id0); else n_pass++;
    n_total++; if (rsp_data0 !== mdat(10'h005)) $display("FAIL k0_data got %h want %h", rsp_data0, mdat(10'h005)); else n_pass++;
    n_total++; if (busy0 !== 1'b1) $display("FAIL k0_busy_t1 got %b want 1", busy0); else n_pass++;
    tick(); #1;
    n_total++; if (rsp_valid0 !== 1'b0 || busy0 !== 1'b0) $display("FAIL k0_idle_t2 got v=%b busy=%b want 0 0", rsp_valid0, busy0); else n_pass++;
    idle(2);
  endtask

  task automatic test_single_k1();
    // Pointer sits at 2 after the previous test; requester 1 is the only one asking.
    req_valid = 4'b0010;
    req_addr[1*AW +: AW] = 10'h010;
    #1;
    n_total++; if (req_ready1 !== 4'b0010 || rd_en1 !== 1'b1 || rd_addr1 !== 10'h010) $display("FAIL k1_rd got rdy=%b en=%b addr=%h want 0010 1 010", req_ready1, rd_en1, rd_addr1); else n_pass++;
    tick();
    req_valid = '0;
    #1;
    n_total++; if (rsp_valid1 !== 1'b0) $display("FAIL k1_early_rsp got %b want 0", rsp_valid1); else n_pass++;
    n_total++; if (rd_en1 !== 1'b1 || rd_addr1 !== 10'h010) $display("FAIL k1_flush got en=%b addr=%h want 1 010", rd_en1, rd_addr1); else n_pass++;
    n_total++; if (busy1 !== 1'b1) $display("FAIL k1_busy got %b want 1", busy1); else n_pass++;
    tick(); #1;
    n_total++; if ({rsp_valid1, rsp_id1} !== {1'b1, 2'd1}) $display("FAIL k1_rsp got v=%b id=%0d want v=1 id=1", rsp_valid1, rsp_id1); else n_pass++;
    n_total++; if (rsp_data1 !== mdat(10'h010)) $display("FAIL k1_data got %h want %h", rsp_data1, mdat(10'h010)); else n_pass++;
    n_total++; if (rd_en1 !== 1'b0) $display("FAIL k1_no_2nd_flush got %b want 0", rd_en1); else n_pass++;
    tick(); #1;
    n_total++; if (rsp_valid1 !== 1'b0 || busy1 !== 1'b0) $display("FAIL k1_one_rsp got v=%b busy=%b want 0 0", rsp_valid1, busy1); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n_rsp;
    n_rsp = 0;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        req_valid = 4'b0001;
        req_addr[0 +: AW] = 10'(k);
      end else begin
        req_valid = '0;
      end
      #1;
      if (k < 8) begin
        n_total++; if (rd_en1 !== 1'b1 || rd_addr1 !== 10'(k)) $display("FAIL b2b_rd k=%0d got en=%b addr=%h want 1 %h", k, rd_en1, rd_addr1, 10'(k)); else n_pass++;
      end else if (k == 8) begin
        n_total++; if (rd_en1 !== 1'b1 || rd_addr1 !== 10'h007) $display("FAIL b2b_flush got en=%b addr=%h want 1 007", rd_en1, rd_addr1); else n_pass++;
      end else begin
        n_total++; if (rd_en1 !== 1'b0) $display("FAIL b2b_no_flush got %b want 0", rd_en1); else n_pass++;
      end
      if (k >= 2) begin
        n_total++;
        if ({rsp_valid1, rsp_id1, rsp_data1} !== {1'b1, 2'd0, mdat(10'(k - 2))})
          $display("FAIL b2b_rsp k=%0d got v=%b id=%0d data=%h want v=1 id=0 data=%h", k, rsp_valid1, rsp_id1, rsp_data1, mdat(10'(k - 2)));
        else n_pass++;
      end else begin
        n_total++; if (rsp_valid1 !== 1'b0) $display("FAIL b2b_early k=%0d got %b want 0", k, rsp_valid1); else n_pass++;
      end
      if (rsp_valid1 === 1'b1) n_rsp++;
      tick();
    end
    #1;
    if (rsp_valid1 === 1'b1) n_rsp++;
    n_total++; if (n_rsp != 8) $display("FAIL b2b_count got %0d want 8", n_rsp); else n_pass++;
    idle(2);
  endtask

  task automatic test_rr_all();
    int cnt[NR];
    logic [NR-1:0] exp_gnt;
    for (int i = 0; i < NR; i++) cnt[i] = 0;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      req_valid = '1;
      #1;
      exp_gnt = 4'b0001 << (c % 4);
      n_total++; if (req_ready0 !== exp_gnt) $display("FAIL rr_all c=%0d got %b want %b", c, req_ready0, exp_gnt); else n_pass++;
      for (int i = 0; i < NR; i++) if (req_ready0[i] === 1'b1) cnt[i]++;
      if (c >= 1) begin
        n_total++;
        if ({rsp_valid0, rsp_id0} !== {1'b1, 2'((c - 1) % 4)})
          $display("FAIL rr_all_rsp c=%0d got v=%b id=%0d want v=1 id=%0d", c, rsp_valid0, rsp_id0, (c - 1) % 4);
        else n_pass++;
      end
      tick();
    end
    for (int i = 0; i < NR; i++) begin
      n_total++; if (cnt[i] != 10) $display("FAIL rr_share req=%0d got %0d want 10", i, cnt[i]); else n_pass++;
    end
    idle(3);
  endtask

  task automatic test_rr_pair();
    logic [NR-1:0] exp_gnt;
    // Pointer is at 3; a lone request from 1 moves it to 1.
    req_valid = 4'b0010;
    #1;
    n_total++; if (req_ready0 !== 4'b0010) $display("FAIL rr_setup got %b want 0010", req_ready0); else n_pass++;
    tick();
    for (int j = 0; j < 3; j++) begin
      req_valid = 4'b1010;
      #1;
      exp_gnt = (j % 2 == 0) ? 4'b1000 : 4'b0010;
      n_total++; if (req_ready0 !== exp_gnt) $display("FAIL rr_pair j=%0d got %b want %b", j, req_ready0, exp_gnt); else n_pass++;
      tick();
    end
    req_valid = '0;
    #1;
    n_total++; if (req_ready0 !== 4'b0000 || rd_en0 !== 1'b0) $display("FAIL rr_none got rdy=%b en=%b want 0000 0", req_ready0, rd_en0); else n_pass++;
    idle(3);
  endtask

  task automatic test_reset_mid_k1();
    req_valid = 4'b0100;
    req_addr[2*AW +: AW] = 10'h033;
    tick();
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    n_total++; if (rsp_valid1 !== 1'b0) $display("FAIL rst_mid_t1 got %b want 0", rsp_valid1); else n_pass++;
    tick(); #1;
    n_total++; if (rsp_valid1 !== 1'b0 || busy1 !== 1'b0) $display("FAIL rst_mid_in got v=%b busy=%b want 0 0", rsp_valid1, busy1); else n_pass++;
    tick();
    rst_n = 1'b1;
    #1;
    n_total++; if (rsp_valid1 !== 1'b0) $display("FAIL rst_mid_rel got %b want 0", rsp_valid1); else n_pass++;
    tick(); #1;
    n_total++; if (rsp_valid1 !== 1'b0 || rd_en1 !== 1'b0) $display("FAIL rst_mid_after got v=%b en=%b want 0 0", rsp_valid1, rd_en1); else n_pass++;
    req_valid = 4'b1000;
    req_addr[3*AW +: AW] = 10'h02A;
    #1;
    n_total++; if (req_ready1 !== 4'b1000 || rd_en1 !== 1'b1) $display("FAIL rst_new_rd got rdy=%b en=%b want 1000 1", req_ready1, rd_en1); else n_pass++;
    tick();
    req_valid = '0;
    #1;
    n_total++; if (rsp_valid1 !== 1'b0 || rd_en1 !== 1'b1 || rd_addr1 !== 10'h02A) $display("FAIL rst_new_flush got v=%b en=%b addr=%h want 0 1 02a", rsp_valid1, rd_en1, rd_addr1); else n_pass++;
    tick(); #1;
    n_total++;
    if ({rsp_valid1, rsp_id1, rsp_data1} !== {1'b1, 2'd3, mdat(10'h02A)})
      $display("FAIL rst_new_rsp got v=%b id=%0d data=%h want v=1 id=3 data=%h", rsp_valid1, rsp_id1, rsp_data1, mdat(10'h02A));
    else n_pass++;
    tick(); #1;
    n_total++; if (rsp_valid1 !== 1'b0) $display("FAIL rst_new_single got %b want 0", rsp_valid1); else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    test_reset();
    test_single_k0();
    test_single_k1();
    test_back_to_back();
    test_rr_all();
    test_rr_pair();
    test_reset_mid_k1();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
